// File: rtl/shifter_right_seq.sv
// Sequential right shifter: logical or arithmetic, one bit per clock by default.
// Define SHIFTER_RIGHT_MULTISTEP_EN to shift 4 bits per clock while 4 or more remain.
module shifter_right_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   arith_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [SHIFT_WIDTH-1:0] shift_value_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  data_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]             r_state;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [SHIFT_WIDTH-1:0] r_count;
    logic                   r_fill;
    logic                   r_busy;
    logic                   r_done;

    logic [SHIFT_WIDTH-1:0] w_step;
    logic [SHIFT_WIDTH-1:0] w_count_dec;
    logic [DATA_WIDTH-1:0]  w_mask;
    logic [DATA_WIDTH-1:0]  w_shifted;
    logic [1:0]             w_state_nxt;
    logic [DATA_WIDTH-1:0]  w_data_nxt;
    logic [SHIFT_WIDTH-1:0] w_count_nxt;
    logic                   w_fill_nxt;

    // Step size for this cycle.
    always_comb begin
        w_step = SHIFT_WIDTH'(1'd1);
`ifdef SHIFTER_RIGHT_MULTISTEP_EN
        if (r_count >= SHIFT_WIDTH'(3'd4)) begin
            w_step = SHIFT_WIDTH'(3'd4);
        end else begin
            w_step = SHIFT_WIDTH'(1'd1);
        end
`endif
    end

    // One shift step; vacated MSBs take the fill bit captured at acceptance.
    always_comb begin
        w_mask      = ~({DATA_WIDTH{1'b1}} >> w_step);
        w_shifted   = (r_data >> w_step) | (w_mask & {DATA_WIDTH{r_fill}});
        w_count_dec = r_count - w_step;
    end

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_count_nxt = r_count;
        w_fill_nxt  = r_fill;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_data_nxt  = data_i;
                    w_count_nxt = shift_value_i;
                    w_fill_nxt  = arith_i & data_i[DATA_WIDTH-1];
                    if (shift_value_i != {SHIFT_WIDTH{1'b0}}) begin
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_data_nxt  = w_shifted;
                w_count_nxt = w_count_dec;
                if (w_count_dec == {SHIFT_WIDTH{1'b0}}) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; status flags are registered from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_data  <= {DATA_WIDTH{1'b0}};
            r_count <= {SHIFT_WIDTH{1'b0}};
            r_fill  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_count <= w_count_nxt;
            r_fill  <= w_fill_nxt;
            r_busy  <= (w_state_nxt == ST_SHIFT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign data_o = r_data;

endmodule

// File: tb/tb_shifter_right_seq.sv
// Scoreboard bench for shifter_right_seq: driver pushes expected results, a negedge monitor checks them.
module tb_shifter_right_seq;

    localparam int DW = 32;
    localparam int SW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          arith_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [SW-1:0] shift_value_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [DW-1:0] data_o;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [DW-1:0] last_exp;

    shifter_right_seq #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .arith_i(arith_i),
        .data_i(data_i), .shift_value_i(shift_value_i),
        .busy_o(busy_o), .done_o(done_o), .data_o(data_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input int n, input logic a);
        if (a) return DW'($signed(d) >>> n);
        else   return d >> n;
    endfunction

    function automatic int ref_lat(input int n);
`ifdef SHIFTER_RIGHT_MULTISTEP_EN
        return n / 4 + n % 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (!rst_i && done_o) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got done_o=1 expected no result at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (data_o !== e.data) begin
                    bad++;
                    $display("FAIL result: got %h expected %h", data_o, e.data);
                end
                total++;
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL latency: done at cycle %0d expected cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    // Present a start for one edge and push what it should produce.
    task automatic start_op(input logic [DW-1:0] d, input int n, input logic a);
        exp_t e;
        data_i        = d;
        shift_value_i = SW'(n);
        arith_i       = a;
        start_i       = 1'b1;
        e.data        = ref_shift(d, n, a);
        e.cyc         = cyc + ref_lat(n);
        last_exp      = e.data;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Wait for done while scrambling idle inputs; busy must hold until done appears.
    task automatic wait_done();
        bit seen = 0;
        if (done_o) seen = 1;
        for (int i = 0; i < 200 && !seen; i++) begin
            check("busy_during_shift", {31'd0, busy_o}, 32'd1);
            data_i        = $urandom;
            shift_value_i = SW'($urandom);
            arith_i       = 1'($urandom);
            @(posedge clk_i);
            #1;
            if (done_o) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL timeout: got no done_o expected done within 200 cycles");
        end else begin
            check("busy_at_done", {31'd0, busy_o}, 32'd0);
        end
    endtask

    task automatic run_op(input logic [DW-1:0] d, input int n, input logic a);
        start_op(d, n, a);
        wait_done();
    endtask

    task automatic idle_hold();
        @(posedge clk_i);
        #1;
        check("idle_hold_data", data_o, last_exp);
        check("idle_done_low", {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        #3;
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_data", data_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        run_op(32'h00000001, 0, 1'b0); idle_hold();
        check("n0_value", last_exp, 32'h00000001);
        run_op(32'hfedcba98, 4, 1'b0); idle_hold();
        check("n4_logical_value", last_exp, 32'h0fedcba9);
        run_op(32'hfedcba98, 4, 1'b1); idle_hold();
        check("n4_arith_value", last_exp, 32'hffedcba9);
        run_op(32'h80000000, 31, 1'b1); idle_hold();
        check("n31_arith_value", last_exp, 32'hffffffff);
        run_op(32'h80000000, 31, 1'b0); idle_hold();
        check("n31_logical_value", last_exp, 32'h00000001);

        // Start pulse during SHIFT must be ignored.
        start_op(32'h12345678, 10, 1'b0);
        @(posedge clk_i);
        #1;
        data_i = 32'hdeadbeef; shift_value_i = 5'd3; arith_i = 1'b1; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done(); idle_hold();
        check("ignored_start_value", last_exp, 32'h00048d15);

        // Asynchronous reset in the middle of a shift.
        start_op(32'hffffffff, 20, 1'b1);
        repeat (5) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        sb.delete();
        #1;
        check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        check("rst_mid_done", {31'd0, done_o}, 32'd0);
        check("rst_mid_data", data_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        run_op(32'hfedcba98, 1, 1'b0); idle_hold();
        check("post_reset_value", last_exp, 32'h7f6e5d4c);

        // Back-to-back start in the DONE cycle.
        run_op(32'hcafef00d, 3, 1'b1);
        start_op(32'h0badc0de, 7, 1'b0);
        check("b2b_busy", {31'd0, busy_o}, 32'd1);
        wait_done();

        // Randomized operations, sometimes back-to-back.
        for (int k = 0; k < 40; k++) begin
            start_op($urandom, int'($urandom_range(0, 31)), 1'($urandom));
            wait_done();
            if ($urandom_range(0, 1) == 0) begin
                idle_hold();
                repeat ($urandom_range(0, 2)) @(posedge clk_i);
                #1;
            end
        end
        repeat (3) @(posedge clk_i);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
